// File: rtl/daio_pkg.sv
// Shared types and default widths for the DAIO frame assembler slice.
package daio_pkg;

    localparam int DATA_BITS_DEF = 24;
    localparam int PRE_BITS_DEF  = 2;
    localparam int GAP_MAX_DEF   = 64;

    localparam logic [1:0] PRE_B = 2'b00;
    localparam logic [1:0] PRE_M = 2'b01;
    localparam logic [1:0] PRE_W = 2'b10;

    typedef enum logic [2:0] {
        HUNT,
        PRE,
        DATA,
        PAR,
        WAIT
    } state_t;

endpackage

// File: rtl/daio_gap_timer.sv
// Saturating count of bit strobes since the last violation; flags the strobe
// that brings the count up to GAP_MAX.
module daio_gap_timer
    import daio_pkg::*;
#(
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic strobe,
    output logic timeout
);

    localparam int              GW   = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0]   LAST = GW'(GAP_MAX - 1);
    localparam logic [GW-1:0]   SAT  = GW'(GAP_MAX);

    logic [GW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (strobe && count != SAT) begin
            count <= count + GW'(1);
        end
    end

    // Saturation keeps this a single pulse per gap rather than a level.
    assign timeout = strobe && !clear && (count == LAST);

endmodule

// File: rtl/daio_frame_assembler.sv
// Assembles preamble type, data word and parity from the biphase decoder's
// bit stream into a parallel word, and tracks receiver lock.
module daio_frame_assembler
    import daio_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int PRE_BITS  = PRE_BITS_DEF,
    parameter int GAP_MAX   = GAP_MAX_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 bit_in,
    input  logic                 bit_strobe,
    input  logic                 viol_in,
    output logic [DATA_BITS-1:0] word_out,
    output logic [PRE_BITS-1:0]  pre_type,
    output logic                 word_valid,
    output logic                 parity_err,
    output logic                 sync_err,
    output logic                 locked
);

    localparam int            CW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_BITS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

    state_t                 state, state_nxt;
    logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [PRE_BITS-1:0]    pre_sr;
    logic [DATA_BITS-1:0]   data_sr;
    logic                   gap_hit;
    logic                   timeout_act;
    logic                   par_calc;
    logic                   frame_done;
    logic                   sync_err_nxt;
    logic                   locked_nxt;

    daio_gap_timer #(.GAP_MAX(GAP_MAX)) u_gap_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (viol_in),
        .strobe  (bit_strobe),
        .timeout (gap_hit)
    );

    assign timeout_act = gap_hit && (state != HUNT);
    assign par_calc    = (^data_sr) ^ bit_in;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= HUNT;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // NOTE: every comb output is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        if (viol_in) begin
            state_nxt   = PRE;
            bit_cnt_nxt = '0;
        end else if (timeout_act) begin
            state_nxt   = HUNT;
            bit_cnt_nxt = '0;
        end else if (bit_strobe) begin
            unique case (state)
                PRE: begin
                    if (bit_cnt == PRE_LAST) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt   = PAR;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end
                PAR:     state_nxt = WAIT;
                default: ;
            endcase
        end
    end

    // A violation mid-frame is a sync error; a gap timeout drops lock silently.
    always_comb begin
        frame_done   = bit_strobe && !viol_in && !timeout_act && (state == PAR);
        sync_err_nxt = viol_in && (state inside {PRE, DATA, PAR});
        locked_nxt   = locked;
        if (sync_err_nxt || timeout_act) begin
            locked_nxt = 1'b0;
        end else if (frame_done && !par_calc) begin
            locked_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_sr     <= '0;
            data_sr    <= '0;
            word_out   <= '0;
            pre_type   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            word_valid <= frame_done;
            sync_err   <= sync_err_nxt;
            locked     <= locked_nxt;
            // Right shift: after a full field the first bit sits in bit 0.
            if (bit_strobe && !viol_in && state == PRE) begin
                pre_sr <= {bit_in, pre_sr[PRE_BITS-1:1]};
            end
            if (bit_strobe && !viol_in && state == DATA) begin
                data_sr <= {bit_in, data_sr[DATA_BITS-1:1]};
            end
            if (frame_done) begin
                word_out   <= data_sr;
                pre_type   <= pre_sr;
                parity_err <= par_calc;
            end
        end
    end

endmodule

// File: tb/tb_daio_frame_assembler.sv
// Directed, table-driven bench for daio_frame_assembler with hand-computed
// expectations plus sequences for truncation, gap timeout and async reset.
module tb_daio_frame_assembler;
    import daio_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        bit_in;
    logic        bit_strobe;
    logic        viol_in;
    logic [23:0] word_out;
    logic [1:0]  pre_type;
    logic        word_valid;
    logic        parity_err;
    logic        sync_err;
    logic        locked;

    int total = 0;
    int bad   = 0;
    int wv_seen = 0;
    int se_seen = 0;
    int wv_snap;
    int se_snap;

    typedef struct {
        logic [1:0]  pre;
        logic [23:0] data;
        logic        par;
        logic [23:0] exp_word;
        logic [1:0]  exp_pre;
        logic        exp_perr;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[7];

    daio_frame_assembler dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bit_in     (bit_in),
        .bit_strobe (bit_strobe),
        .viol_in    (viol_in),
        .word_out   (word_out),
        .pre_type   (pre_type),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample #1 after the next rising edge.
    task automatic step(input logic s, input logic b, input logic v);
        @(negedge clock);
        bit_strobe = s;
        bit_in     = b;
        viol_in    = v;
        @(posedge clock);
        #1;
        wv_seen += int'(word_valid);
        se_seen += int'(sync_err);
    endtask

    task automatic send_bit(input logic b);
        step(1'b1, b, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Ends right after the parity-strobe edge so the caller can check outputs.
    task automatic send_frame(input logic [1:0] pre, input logic [23:0] data,
                              input logic par, input logic with_viol);
        if (with_viol) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) send_bit(pre[i]);
        for (int i = 0; i < 24; i++) send_bit(data[i]);
        step(1'b1, par, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".word_out"},   32'(word_out),   32'h0);
        check({tag, ".pre_type"},   32'(pre_type),   32'h0);
        check({tag, ".word_valid"}, 32'(word_valid), 32'h0);
        check({tag, ".parity_err"}, 32'(parity_err), 32'h0);
        check({tag, ".sync_err"},   32'(sync_err),   32'h0);
        check({tag, ".locked"},     32'(locked),     32'h0);
    endtask

    initial begin
        //            pre    data        par   exp_word    exp_pre perr lock
        vecs[0] = '{PRE_M, 24'hA5A5A5, 1'b1, 24'hA5A5A5, PRE_M, 1'b1, 1'b0};
        vecs[1] = '{PRE_M, 24'hA5A5A5, 1'b0, 24'hA5A5A5, PRE_M, 1'b0, 1'b1};
        vecs[2] = '{PRE_B, 24'h000000, 1'b0, 24'h000000, PRE_B, 1'b0, 1'b1};
        vecs[3] = '{PRE_W, 24'hFFFFFF, 1'b1, 24'hFFFFFF, PRE_W, 1'b1, 1'b1};
        vecs[4] = '{PRE_M, 24'h000001, 1'b1, 24'h000001, PRE_M, 1'b0, 1'b1};
        vecs[5] = '{PRE_W, 24'h800000, 1'b0, 24'h800000, PRE_W, 1'b1, 1'b1};
        vecs[6] = '{PRE_B, 24'h123456, 1'b1, 24'h123456, PRE_B, 1'b0, 1'b1};

        reset_n    = 1'b0;
        bit_in     = 1'b0;
        bit_strobe = 1'b0;
        viol_in    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("in_reset");
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_zero_outputs("after_reset");

        // Table-driven frames: parity error first (no lock), then clean ones.
        for (int k = 0; k < 7; k++) begin
            wv_snap = wv_seen;
            se_snap = se_seen;
            send_frame(vecs[k].pre, vecs[k].data, vecs[k].par, 1'b1);
            check($sformatf("v%0d.word_valid", k), 32'(word_valid), 32'h1);
            check($sformatf("v%0d.word_out", k),   32'(word_out),   32'(vecs[k].exp_word));
            check($sformatf("v%0d.pre_type", k),   32'(pre_type),   32'(vecs[k].exp_pre));
            check($sformatf("v%0d.parity_err", k), 32'(parity_err), 32'(vecs[k].exp_perr));
            check($sformatf("v%0d.locked", k),     32'(locked),     32'(vecs[k].exp_lock));
            check($sformatf("v%0d.wv_count", k),   32'(wv_seen - wv_snap), 32'd1);
            check($sformatf("v%0d.se_count", k),   32'(se_seen - se_snap), 32'd0);
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("v%0d.wv_pulse_end", k), 32'(word_valid), 32'h0);
        end

        // Truncation: violation after 10 data bits.
        wv_snap = wv_seen;
        se_snap = se_seen;
        step(1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("trunc.locked_before", 32'(locked), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        check("trunc.sync_err", 32'(sync_err), 32'h1);
        check("trunc.locked",   32'(locked),   32'h0);
        step(1'b0, 1'b0, 1'b0);
        check("trunc.sync_err_end", 32'(sync_err), 32'h0);
        check("trunc.wv_count", 32'(wv_seen - wv_snap), 32'd0);
        send_frame(PRE_W, 24'h000001, 1'b1, 1'b0);
        check("trunc.next_valid",  32'(word_valid), 32'h1);
        check("trunc.next_word",   32'(word_out),   32'h000001);
        check("trunc.next_pre",    32'(pre_type),   32'(PRE_W));
        check("trunc.next_locked", 32'(locked),     32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Violation and strobe together in DATA: the strobe bit is dropped.
        step(1'b0, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("simul.sync_err", 32'(sync_err), 32'h1);
        check("simul.locked",   32'(locked),   32'h0);
        send_frame(PRE_M, 24'h00000F, 1'b0, 1'b0);
        check("simul.valid",  32'(word_valid), 32'h1);
        check("simul.word",   32'(word_out),   32'h00000F);
        check("simul.pre",    32'(pre_type),   32'(PRE_M));
        check("simul.perr",   32'(parity_err), 32'h0);
        check("simul.locked2", 32'(locked),    32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Gap timeout: 64 strobes since the last violation drops lock.
        send_frame(PRE_M, 24'hA5A5A5, 1'b0, 1'b1);
        check("gap.locked_frame", 32'(locked), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        wv_snap = wv_seen;
        se_snap = se_seen;
        for (int i = 0; i < 36; i++) send_bit(1'b1);
        check("gap.locked_63", 32'(locked), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        check("gap.locked_64", 32'(locked),   32'h0);
        check("gap.sync_err",  32'(sync_err), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        send_frame(PRE_M, 24'hA5A5A5, 1'b0, 1'b0);
        check("gap.hunt_no_valid", 32'(word_valid), 32'h0);
        check("gap.hunt_locked",   32'(locked),     32'h0);
        check("gap.wv_count", 32'(wv_seen - wv_snap), 32'd0);
        check("gap.se_count", 32'(se_seen - se_snap), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        send_frame(PRE_W, 24'h123456, 1'b1, 1'b1);
        check("gap.recover_valid",  32'(word_valid), 32'h1);
        check("gap.recover_word",   32'(word_out),   32'h123456);
        check("gap.recover_locked", 32'(locked),     32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Async reset between clock edges in the middle of DATA.
        step(1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        wv_snap = wv_seen;
        send_frame(PRE_M, 24'hA5A5A5, 1'b0, 1'b0);
        check("post_rst.no_valid", 32'(word_valid), 32'h0);
        check("post_rst.locked",   32'(locked),     32'h0);
        check("post_rst.wv_count", 32'(wv_seen - wv_snap), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        send_frame(PRE_B, 24'h5A5A5A, 1'b0, 1'b1);
        check("post_rst.valid",  32'(word_valid), 32'h1);
        check("post_rst.word",   32'(word_out),   32'h5A5A5A);
        check("post_rst.locked", 32'(locked),     32'h1);
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
